// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (evaluated in mem_arb_pick).
package mem_arb_pkg;

  // Width of the WAIT-state watchdog counter (holds values up to 63).
  localparam int WDOG_W = 6;

  // Arbiter FSM state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ERR   = 2'd3
  } arb_state_e;

  // Owner of the access in flight.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and data ports.
// MEM_ARB_ROUND_ROBIN_EN defined  : two-way round robin using last_grant_i.
// MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, the data port wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req_i,
  input  logic   d_req_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  owner_e last_grant_i,
`endif
  output logic   grant_valid_o,
  output owner_e grant_owner_o
);

  // Pick a winner from the raw request bits.
  always_comb begin
    grant_valid_o = i_req_i | d_req_i;
    grant_owner_o = OWN_D;
    if (i_req_i && d_req_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      grant_owner_o = (last_grant_i == OWN_D) ? OWN_I : OWN_D;
`else
      grant_owner_o = OWN_D;
`endif
    end else if (i_req_i) begin
      grant_owner_o = OWN_I;
    end else begin
      grant_owner_o = OWN_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory system between instruction fetch and
// data load/store. IDLE samples requests, ISSUE pulses m_rd/m_wr for one cycle,
// WAIT holds address/data until m_done (or the watchdog expires), ERR is sticky.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin tie breaking).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int WDOG_MAX = 63
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch port
  input  logic              i_rd,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_data_out,
  output logic              i_done,
  output logic              i_stall,
  // data port
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_data_in,
  output logic [DATA_W-1:0] d_data_out,
  output logic              d_done,
  output logic              d_stall,
  // memory system side
  output logic              m_rd,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data_in,
  input  logic [DATA_W-1:0] m_data_out,
  input  logic              m_done,
  input  logic              m_err,
  // sticky error
  output logic              err
);

  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_MAX);
  localparam logic [WDOG_W-1:0] WDOG_ONE   = WDOG_W'(1);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              req_wr_q, req_wr_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  logic              d_req_s;
  logic              grant_valid_s;
  owner_e            grant_owner_s;
  logic              done_ok_s;

  assign d_req_s = d_rd | d_wr;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_e last_grant_q, last_grant_d;
`endif

  mem_arb_pick u_pick (
    .i_req_i       (i_rd),
    .d_req_i       (d_req_s),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last_grant_i  (last_grant_q),
`endif
    .grant_valid_o (grant_valid_s),
    .grant_owner_o (grant_owner_s)
  );

  // State, latched request and watchdog registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_D;
      req_wr_q   <= 1'b0;
      req_addr_q <= {ADDR_W{1'b0}};
      req_data_q <= {DATA_W{1'b0}};
      wdog_q     <= {WDOG_W{1'b0}};
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      req_wr_q   <= req_wr_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      wdog_q     <= wdog_d;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Remember which port won the most recent grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= OWN_D;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Next-state logic: sample in IDLE, pulse in ISSUE, count in WAIT; m_err wins.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    req_wr_d   = req_wr_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    wdog_d     = wdog_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    if (m_err) begin
      state_d = ST_ERR;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (d_rd && d_wr) begin
            state_d = ST_ERR;
          end else if (grant_valid_s) begin
            owner_d = grant_owner_s;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_d = grant_owner_s;
`endif
            if (grant_owner_s == OWN_D) begin
              req_wr_d   = d_wr;
              req_addr_d = d_addr;
              req_data_d = d_data_in;
            end else begin
              req_wr_d   = 1'b0;
              req_addr_d = i_addr;
              req_data_d = {DATA_W{1'b0}};
            end
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ISSUE: begin
          wdog_d  = {WDOG_W{1'b0}};
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (m_done) begin
            state_d = ST_IDLE;
          end else begin
            wdog_d = wdog_q + WDOG_ONE;
            if (wdog_d == WDOG_LIMIT) begin
              state_d = ST_ERR;
            end else begin
              state_d = ST_WAIT;
            end
          end
        end
        ST_ERR: begin
          state_d = ST_ERR;
        end
        default: begin
          state_d = ST_ERR;
        end
      endcase
    end
  end

  // A completion is forwarded only in WAIT and only when no error accompanies it.
  assign done_ok_s = (state_q == ST_WAIT) && m_done && !m_err;

  assign i_done     = done_ok_s && (owner_q == OWN_I);
  assign d_done     = done_ok_s && (owner_q == OWN_D);
  assign i_data_out = i_done ? m_data_out : {DATA_W{1'b0}};
  assign d_data_out = d_done ? m_data_out : {DATA_W{1'b0}};
  assign i_stall    = i_rd & ~i_done;
  assign d_stall    = d_req_s & ~d_done;

  assign m_rd      = (state_q == ST_ISSUE) && !req_wr_q;
  assign m_wr      = (state_q == ST_ISSUE) &&  req_wr_q;
  assign m_addr    = req_addr_q;
  assign m_data_in = req_data_q;
  assign err       = (state_q == ST_ERR);

endmodule
